rv32i_run_monitor: RTL
======================

// Module: rv32i_run_monitor
// PURPOSE
// Synthesisable run controller for the RV32i SoC: sequences core reset release, detects the halt instruction and drains the pipeline.
// Flags completion or a watchdog timeout.
// Sits between the SoC top and the core.
// Drives the core's active-low reset and snoops the instruction-memory read data.
// Generalises halt detection (parametrised opcode, repeat count), reset/drain lengths and adds a watchdog.
// PARAMETERS
// HALT_INSN     32'h0000006F  instruction word treated as halt (jal x0,0)
// HALT_REPEAT   1             consecutive valid matches required to declare halt (>=1)
// RESET_CYCLES  5             cycles core_resetn_o held low after leaving reset (>=1)
// DRAIN_CYCLES  5             cycles waited after halt before done_o (0 allowed)
// CNT_W         32            width of cycle counter and watchdog limit
// PORTS
// clk_i          in   1       clock, rising edge
// rst_i          in   1       asynchronous reset, active-high
// inst_i         in   32      instruction word fetched by the core (imem read data)
// inst_valid_i   in   1       inst_i is a real fetch this cycle
// timeout_lim_i  in   CNT_W   watchdog limit in RUN cycles; 0 = watchdog disabled
// core_resetn_o  out  1       active-low reset to the core
// running_o      out  1       high in RUN and DRAIN
// done_o         out  1       sticky, halt seen and drain complete
// timeout_o      out  1       sticky, watchdog expired before halt
// cycle_cnt_o    out  CNT_W   cycles spent in RUN+DRAIN, saturating
// BEHAVIOUR
// - Reset (rst_i=1, async): state=RST_HOLD, core_resetn_o=0, running_o=0, done_o=0, timeout_o=0, cycle_cnt_o=0, all internal counters 0.
// - All outputs are registered. No combinational path from inputs to outputs.
// - FSM states and transitions:
//   RST_HOLD: count RESET_CYCLES clocks after rst_i deasserts, then go to RUN. core_resetn_o goes 1 on the edge entering RUN.
//   RUN:      running_o=1. cycle_cnt_o increments each cycle.
//             Match counter increments on (inst_valid_i && inst_i==HALT_INSN).
//             Match counter clears on a valid non-match.
//             Match counter holds when inst_valid_i=0.
//             When the match count reaches HALT_REPEAT, go to DRAIN (DRAIN_CYCLES>0) or DONE (DRAIN_CYCLES=0).
//             If timeout_lim_i!=0 and cycle_cnt_o==timeout_lim_i-1, go to TIMEOUT.
//   DRAIN:    running_o=1. cycle_cnt_o keeps incrementing. After DRAIN_CYCLES cycles go to DONE. The watchdog is ignored.
//   DONE:     done_o=1, running_o=0, core_resetn_o stays 1. Terminal state until rst_i.
//   TIMEOUT:  timeout_o=1, running_o=0, core_resetn_o=0 (core frozen). Terminal state until rst_i.
// - Latency: with HALT_REPEAT=1, done_o rises DRAIN_CYCLES+1 clocks after the edge sampling the halt word.
// - Simultaneous halt-match completion and watchdog expiry in one cycle: halt wins (DRAIN/DONE). timeout_o stays 0.
// - cycle_cnt_o saturates at all-ones; it never wraps. The watchdog compare uses the saturated value.
// - timeout_lim_i is sampled every cycle. Changing it mid-run takes effect immediately.
// - rst_i asserted in any state returns to RST_HOLD asynchronously. All outputs take their reset values at once.
// - done_o and timeout_o are mutually exclusive. Never both 1.
// CONFIGURATION
// RUN_MON_INSTRET_EN defined:
// - Adds output instret_o [CNT_W-1:0].
// - instret_o counts inst_valid_i cycles in RUN only (not DRAIN), saturating, reset 0.
// - instret_o freezes in DONE/TIMEOUT.
// RUN_MON_INSTRET_EN undefined: the port and counter are absent. All other behaviour is identical.
// TESTING
// T1 basic: defaults, lim=0, halt on valid fetch at RUN cycle 20 -> done_o=1 6 clocks later, cycle_cnt_o=26, timeout_o=0.
// T2 reset seq: release rst_i -> core_resetn_o=0 for exactly 5 clocks, then 1; running_o rises on the same edge.
// T3 watchdog: lim=100, never halt -> timeout_o=1 after 100 RUN cycles, core_resetn_o=0, done_o=0, cycle_cnt_o=100.
// T4 repeat: HALT_REPEAT=3; matches on cycles 10,11 then non-match, then 3 matches with inst_valid_i=0 gaps between -> halt declared only on the 3rd match of the second run.
// T5 tie: lim=21, halt completes on RUN cycle 21 -> DRAIN entered, timeout_o stays 0, done_o asserts.
// T6 mid-reset: assert rst_i during DRAIN -> all outputs reset immediately; rerun reaches done_o. With RUN_MON_INSTRET_EN, instret_o equals the number of valid fetches in RUN.

Source files
------------

// File: rtl/rv32i_run_monitor_if.sv
// Run-monitor signal bundle between the SoC top (master) and rv32i_run_monitor (slave).
// With RUN_MON_INSTRET_EN defined the bundle also carries instret_o.
interface rv32i_run_monitor_if #(
  parameter int unsigned CNT_W = 32
);
  logic [31:0]      inst_i;
  logic             inst_valid_i;
  logic [CNT_W-1:0] timeout_lim_i;
  logic             core_resetn_o;
  logic             running_o;
  logic             done_o;
  logic             timeout_o;
  logic [CNT_W-1:0] cycle_cnt_o;
`ifdef RUN_MON_INSTRET_EN
  logic [CNT_W-1:0] instret_o;

  modport master (
    output inst_i, inst_valid_i, timeout_lim_i,
    input  core_resetn_o, running_o, done_o, timeout_o, cycle_cnt_o, instret_o
  );
  modport slave (
    input  inst_i, inst_valid_i, timeout_lim_i,
    output core_resetn_o, running_o, done_o, timeout_o, cycle_cnt_o, instret_o
  );
`else
  modport master (
    output inst_i, inst_valid_i, timeout_lim_i,
    input  core_resetn_o, running_o, done_o, timeout_o, cycle_cnt_o
  );
  modport slave (
    input  inst_i, inst_valid_i, timeout_lim_i,
    output core_resetn_o, running_o, done_o, timeout_o, cycle_cnt_o
  );
`endif
endinterface

// File: rtl/rv32i_run_monitor.sv
// RV32i run controller: core reset sequencing, halt detection, pipeline drain and watchdog.
// Optional retired-fetch counter instret_o enabled by defining RUN_MON_INSTRET_EN.
module rv32i_run_monitor #(
  parameter logic [31:0] HALT_INSN    = 32'h0000006F,
  parameter int unsigned HALT_REPEAT  = 1,
  parameter int unsigned RESET_CYCLES = 5,
  parameter int unsigned DRAIN_CYCLES = 5,
  parameter int unsigned CNT_W        = 32
) (
  input logic               clk_i,
  input logic               rst_i,
  rv32i_run_monitor_if.slave mon
);
  localparam int unsigned MW = $clog2(HALT_REPEAT + 1);
  localparam int unsigned DW = (DRAIN_CYCLES == 0) ? 1 : $clog2(DRAIN_CYCLES + 1);
  localparam int unsigned RW = (RESET_CYCLES < 2) ? 1 : $clog2(RESET_CYCLES);

  typedef enum logic [2:0] {RST_HOLD, RUN, DRAIN, DONE, TIMEOUT} state_e;

  state_e           state_q;
  logic [RW-1:0]    rst_cnt_q;
  logic [MW-1:0]    match_q;
  logic [DW-1:0]    drain_q;
  logic             core_resetn_q, running_q, done_q, timeout_q;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic             match_valid, halt_hit, wdog_hit;
`ifdef RUN_MON_INSTRET_EN
  logic [CNT_W-1:0] instret_q, instret_d;
`endif

  always_comb begin
    cycle_cnt_d = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
    match_valid = mon.inst_valid_i && (mon.inst_i == HALT_INSN);
    halt_hit    = match_valid && (match_q == MW'(HALT_REPEAT - 1));
    wdog_hit    = (mon.timeout_lim_i != '0) &&
                  (cycle_cnt_q == mon.timeout_lim_i - CNT_W'(1));
`ifdef RUN_MON_INSTRET_EN
    instret_d   = instret_q;
    if (mon.inst_valid_i && (instret_q != '1)) instret_d = instret_q + CNT_W'(1);
`endif
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= RST_HOLD;
      rst_cnt_q     <= '0;
      match_q       <= '0;
      drain_q       <= '0;
      core_resetn_q <= 1'b0;
      running_q     <= 1'b0;
      done_q        <= 1'b0;
      timeout_q     <= 1'b0;
      cycle_cnt_q   <= '0;
`ifdef RUN_MON_INSTRET_EN
      instret_q     <= '0;
`endif
    end else begin
      case (state_q)
        RST_HOLD: begin
          if (rst_cnt_q == RW'(RESET_CYCLES - 1)) begin
            state_q       <= RUN;
            core_resetn_q <= 1'b1;
            running_q     <= 1'b1;
          end else begin
            rst_cnt_q <= rst_cnt_q + RW'(1);
          end
        end
        RUN: begin
          cycle_cnt_q <= cycle_cnt_d;
`ifdef RUN_MON_INSTRET_EN
          instret_q   <= instret_d;
`endif
          // Halt completion is tested before the watchdog so a same-cycle tie resolves to halt.
          if (halt_hit) begin
            match_q <= '0;
            if (DRAIN_CYCLES == 0) begin
              state_q   <= DONE;
              running_q <= 1'b0;
              done_q    <= 1'b1;
            end else begin
              state_q <= DRAIN;
            end
          end else begin
            if (match_valid)             match_q <= match_q + MW'(1);
            else if (mon.inst_valid_i)   match_q <= '0;
            if (wdog_hit) begin
              state_q       <= TIMEOUT;
              running_q     <= 1'b0;
              core_resetn_q <= 1'b0;
              timeout_q     <= 1'b1;
            end
          end
        end
        DRAIN: begin
          cycle_cnt_q <= cycle_cnt_d;
          // DRAIN spans DRAIN_CYCLES+1 cycles, so done_o lands DRAIN_CYCLES+1 clocks after the halt edge.
          if (drain_q == DW'(DRAIN_CYCLES)) begin
            state_q   <= DONE;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            drain_q <= drain_q + DW'(1);
          end
        end
        DONE, TIMEOUT: ;
        default: state_q <= RST_HOLD;
      endcase
    end
  end

  assign mon.core_resetn_o = core_resetn_q;
  assign mon.running_o     = running_q;
  assign mon.done_o        = done_q;
  assign mon.timeout_o     = timeout_q;
  assign mon.cycle_cnt_o   = cycle_cnt_q;
`ifdef RUN_MON_INSTRET_EN
  assign mon.instret_o     = instret_q;
`endif
endmodule
